// File: rtl/link_mgmt_pkg.sv
// Shared definitions for the L0p link-management DLLP transmitter:
// DLLP header constants, FSM state encoding and the DLLP CRC-16.
package link_mgmt_pkg;

  localparam logic [7:0]  DLLP_TYPE_L0P = 8'h28;
  localparam logic [7:0]  L0P_SUBTYPE   = 8'h00;
  localparam logic [15:0] CRC_POLY      = 16'h100B;
  localparam logic [15:0] CRC_SEED      = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUILD    = 2'd1,
    SEND     = 2'd2,
    WAIT_RSP = 2'd3
  } state_t;

  // Bit-serial CRC, MSB of byte 31:24 first; the remainder is inverted on output.
  function automatic logic [15:0] crc16_dllp(input logic [31:0] body);
    logic [15:0] c;
    logic        fb;
    c = CRC_SEED;
    for (int i = 31; i >= 0; i--) begin
      fb = c[15] ^ body[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return ~c;
  endfunction

endpackage

// File: rtl/dllp_crc16.sv
// Combinational DLLP CRC-16 over the 32-bit DLLP body.
module dllp_crc16
  import link_mgmt_pkg::*;
(
  input  logic [31:0] body,
  output logic [15:0] crc
);

  assign crc = crc16_dllp(body);

endmodule

// File: rtl/link_mgmt_dllp_tx.sv
// L0p link-management DLLP transmitter: builds one DLLP per request, sends it,
// and for request commands waits for the partner response with bounded retries.
module link_mgmt_dllp_tx
  import link_mgmt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_priority,
  input  logic [3:0]  req_cmd,
  input  logic [2:0]  req_rsp_payload,
  input  logic [2:0]  req_link_width,
  output logic        dllp_valid,
  input  logic        dllp_ready,
  output logic [47:0] dllp_data,
  input  logic        rsp_valid,
  output logic        done,
  output logic        timeout_err,
  output logic        busy
);

  localparam logic [15:0] TIMER_LOAD  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

  state_t      state_reg;
  logic        prio_reg;
  logic [3:0]  cmd_reg;
  logic [2:0]  payload_reg;
  logic [2:0]  width_reg;
  logic [15:0] timer_reg;
  logic [2:0]  retry_cnt_reg;
  logic [31:0] body;
  logic [15:0] crc;

  assign body = {DLLP_TYPE_L0P, L0P_SUBTYPE, prio_reg, cmd_reg, payload_reg,
                 5'b00000, width_reg};

  dllp_crc16 u_crc (
    .body (body),
    .crc  (crc)
  );

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      prio_reg      <= 1'b0;
      cmd_reg       <= 4'h0;
      payload_reg   <= 3'h0;
      width_reg     <= 3'h0;
      timer_reg     <= 16'h0000;
      retry_cnt_reg <= 3'h0;
      dllp_valid    <= 1'b0;
      dllp_data     <= 48'h0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            prio_reg      <= req_priority;
            cmd_reg       <= req_cmd;
            payload_reg   <= req_rsp_payload;
            width_reg     <= req_link_width;
            retry_cnt_reg <= 3'h0;
            state_reg     <= BUILD;
          end
        end
        BUILD: begin
          dllp_data  <= {body, crc};
          dllp_valid <= 1'b1;
          state_reg  <= SEND;
        end
        SEND: begin
          // The timer is untouched here so a stalled link never burns a retry.
          if (dllp_ready) begin
            dllp_valid <= 1'b0;
            if (cmd_reg[3]) begin
              done      <= 1'b1;
              state_reg <= IDLE;
            end else begin
              timer_reg <= TIMER_LOAD;
              state_reg <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          // A response arriving on the expiry cycle takes precedence.
          if (rsp_valid) begin
            done      <= 1'b1;
            state_reg <= IDLE;
          end else if (timer_reg == 16'h0000) begin
            if (retry_cnt_reg < RETRY_LIMIT) begin
              retry_cnt_reg <= retry_cnt_reg + 3'h1;
              dllp_valid    <= 1'b1;
              state_reg     <= SEND;
            end else begin
              timeout_err <= 1'b1;
              state_reg   <= IDLE;
            end
          end else begin
            timer_reg <= timer_reg - 16'h0001;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_mgmt_dllp_tx.sv
// Self-checking bench for link_mgmt_dllp_tx: table vectors, directed corner
// sequences and randomized transactions scored against a transaction-level model.
module tb_link_mgmt_dllp_tx;

  localparam int TA = 8;   // timeout of the main instance
  localparam int RA = 2;   // retries of the main instance
  localparam int TB = 16;
  localparam int RB = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_priority = 1'b0;
  logic [3:0]  req_cmd = 4'h0;
  logic [2:0]  req_rsp_payload = 3'h0;
  logic [2:0]  req_link_width = 3'h0;
  logic        dllp_ready = 1'b0;
  logic        rsp_valid = 1'b0;

  logic        req_ready, dllp_valid, done, timeout_err, busy;
  logic [47:0] dllp_data;
  logic        req_ready_b, dllp_valid_b, done_b, timeout_err_b, busy_b;
  logic [47:0] dllp_data_b;

  int tests = 0;
  int failed = 0;
  int hs_b = 0;
  int done_b_cnt = 0;
  int to_b_cnt = 0;

  always #5 clk = ~clk;

  link_mgmt_dllp_tx #(.TIMEOUT_CYCLES(TA), .MAX_RETRY(RA)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_priority(req_priority), .req_cmd(req_cmd), .req_rsp_payload(req_rsp_payload),
    .req_link_width(req_link_width), .dllp_valid(dllp_valid), .dllp_ready(dllp_ready),
    .dllp_data(dllp_data), .rsp_valid(rsp_valid), .done(done),
    .timeout_err(timeout_err), .busy(busy)
  );

  link_mgmt_dllp_tx #(.TIMEOUT_CYCLES(TB), .MAX_RETRY(RB)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_priority(req_priority), .req_cmd(req_cmd), .req_rsp_payload(req_rsp_payload),
    .req_link_width(req_link_width), .dllp_valid(dllp_valid_b), .dllp_ready(dllp_ready),
    .dllp_data(dllp_data_b), .rsp_valid(rsp_valid), .done(done_b),
    .timeout_err(timeout_err_b), .busy(busy_b)
  );

  always @(posedge clk) begin
    if (dllp_valid_b && dllp_ready) hs_b++;
    if (done_b) done_b_cnt++;
    if (timeout_err_b) to_b_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Byte-wise reference CRC, independent of the design's bit-serial form.
  function automatic logic [15:0] crc_model(input logic [31:0] b);
    logic [15:0] c;
    logic [7:0]  by;
    c = 16'hFFFF;
    for (int k = 3; k >= 0; k--) begin
      by = b[k*8 +: 8];
      c  = c ^ {by, 8'h00};
      for (int j = 0; j < 8; j++)
        c = c[15] ? ((c << 1) ^ 16'h100B) : (c << 1);
    end
    return ~c;
  endfunction

  // fails = number of unanswered attempts; dly = response delay (1..TA) on the answered one.
  task automatic run_txn(input logic prio, input logic [3:0] cmd, input logic [2:0] pl,
                         input logic [2:0] w, input int stall, input int fails, input int dly);
    logic [31:0] exp_body;
    logic [47:0] exp_word;
    int attempts, sends;
    bit last, expect_to;
    exp_body  = {8'h28, 8'h00, prio, cmd, pl, 5'b00000, w};
    exp_word  = {exp_body, crc_model(exp_body)};
    expect_to = !cmd[3] && (fails > RA);
    attempts  = cmd[3] ? 1 : (expect_to ? RA + 1 : fails + 1);
    sends = 0;
    chk("req_ready_idle", {47'd0, req_ready}, 48'd1);
    req_valid = 1'b1; req_priority = prio; req_cmd = cmd;
    req_rsp_payload = pl; req_link_width = w;
    tick();
    req_valid = 1'b0;
    req_priority = 1'($urandom); req_cmd = 4'($urandom);
    req_rsp_payload = 3'($urandom); req_link_width = 3'($urandom);
    rsp_valid = 1'($urandom);
    chk("build_state", {46'd0, busy, dllp_valid}, 48'd2);
    tick();
    rsp_valid = 1'b0;
    for (int a = 0; a < attempts; a++) begin
      last = (a == attempts - 1);
      chk("dllp_valid_rise", {47'd0, dllp_valid}, 48'd1);
      chk("dllp_data", dllp_data, exp_word);
      for (int s = 0; s < stall; s++) begin
        dllp_ready = 1'b0;
        rsp_valid  = 1'($urandom);
        tick();
        chk("stall_valid", {47'd0, dllp_valid}, 48'd1);
        chk("stall_data", dllp_data, exp_word);
      end
      rsp_valid = 1'b0;
      dllp_ready = 1'b1;
      tick();
      dllp_ready = 1'b0;
      sends++;
      chk("post_send_valid", {47'd0, dllp_valid}, 48'd0);
      if (cmd[3]) begin
        chk("done_on_send", {46'd0, done, timeout_err}, 48'd2);
        chk("ready_after_rsp_cmd", {47'd0, req_ready}, 48'd1);
      end else if (!last || expect_to) begin
        for (int k = 1; k < TA; k++) begin
          tick();
          chk("wait_quiet", {45'd0, dllp_valid, done, timeout_err}, 48'd0);
        end
        tick();
        if (last) begin
          chk("timeout_pulse", {45'd0, dllp_valid, done, timeout_err}, 48'd1);
          chk("ready_after_timeout", {47'd0, req_ready}, 48'd1);
        end
      end else begin
        for (int k = 1; k < dly; k++) begin
          tick();
          chk("wait_quiet", {45'd0, dllp_valid, done, timeout_err}, 48'd0);
        end
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        chk("done_on_rsp", {45'd0, dllp_valid, done, timeout_err}, 48'd2);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_after_txn", {44'd0, dllp_valid, done, timeout_err, busy}, 48'd0);
    end
    $display("[TB] txn cmd=%h prio=%b pl=%0d w=%0d stall=%0d sends=%0d result=%s",
             cmd, prio, pl, w, stall, sends, expect_to ? "timeout" : "done");
  endtask

  typedef struct {
    logic        prio;
    logic [3:0]  cmd;
    logic [2:0]  pl;
    logic [2:0]  w;
    int          stall;
    int          fails;
    int          dly;
    logic [31:0] exp_body;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 4'hA, 3'd5, 3'd4, 0,  0, 1,  32'h2800_D504};
    tbl[1] = '{1'b0, 4'h3, 3'd0, 3'd7, 0,  0, 5,  32'h2800_1807};
    tbl[2] = '{1'b0, 4'h2, 3'd1, 3'd1, 0,  3, 1,  32'h2800_1101};
    tbl[3] = '{1'b1, 4'h0, 3'd7, 3'd2, 20, 3, 1,  32'h2800_8702};
    tbl[4] = '{1'b0, 4'hF, 3'd2, 3'd3, 20, 0, 1,  32'h2800_7A03};
    tbl[5] = '{1'b1, 4'h5, 3'd3, 3'd5, 1,  0, TA, 32'h2800_AB05};
    tbl[6] = '{1'b0, 4'h6, 3'd4, 3'd6, 2,  2, TA, 32'h2800_3406};

    // Reset values, asserted before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_ready_busy", {46'd0, req_ready, busy}, 48'd2);
    chk("rst_pulses", {45'd0, dllp_valid, done, timeout_err}, 48'd0);
    chk("rst_data", dllp_data, 48'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("crc_pkg_fn", {32'd0, link_mgmt_pkg::crc16_dllp(32'h2800_D504)},
        {32'd0, crc_model(32'h2800_D504)});

    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1; req_priority = tbl[i].prio; req_cmd = tbl[i].cmd;
      req_rsp_payload = tbl[i].pl; req_link_width = tbl[i].w;
      #0;
      chk("table_body_pre", {47'd0, req_ready}, 48'd1);
      req_valid = 1'b0;
      run_txn(tbl[i].prio, tbl[i].cmd, tbl[i].pl, tbl[i].w,
              tbl[i].stall, tbl[i].fails, tbl[i].dly);
      chk("table_body", {16'd0, dllp_data[47:16]}, {16'd0, tbl[i].exp_body});
    end

    // Asynchronous reset while waiting for a response.
    req_valid = 1'b1; req_cmd = 4'h1; req_priority = 1'b0;
    req_rsp_payload = 3'd2; req_link_width = 3'd3;
    tick();
    req_valid = 1'b0;
    tick();
    dllp_ready = 1'b1;
    tick();
    dllp_ready = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_wait_busy", {47'd0, busy}, 48'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready_busy", {46'd0, req_ready, busy}, 48'd2);
    chk("async_rst_pulses", {45'd0, dllp_valid, done, timeout_err}, 48'd0);
    chk("async_rst_data", dllp_data, 48'd0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < TA + 4; k++) begin
      tick();
      chk("abandoned_quiet", {45'd0, dllp_valid, done, timeout_err}, 48'd0);
    end
    run_txn(1'b1, 4'h4, 3'd6, 3'd1, 1, 1, 3);

    // Response ten cycles after the send, on the long-timeout instance.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    begin
      int hs0, d0, t0;
      hs0 = hs_b; d0 = done_b_cnt; t0 = to_b_cnt;
      req_valid = 1'b1; req_cmd = 4'h3; req_priority = 1'b0;
      req_rsp_payload = 3'd1; req_link_width = 3'd2;
      tick();
      req_valid = 1'b0;
      tick();
      chk("b_valid", {47'd0, dllp_valid_b}, 48'd1);
      dllp_ready = 1'b1;
      tick();
      for (int k = 1; k < 10; k++) begin
        tick();
        chk("b_wait_quiet", {46'd0, done_b, timeout_err_b}, 48'd0);
      end
      rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0;
      chk("b_done_pulse", {46'd0, done_b, timeout_err_b}, 48'd2);
      for (int k = 0; k < TB + 4; k++) tick();
      dllp_ready = 1'b0;
      chk("b_one_dllp", 48'(hs_b - hs0), 48'd1);
      chk("b_one_done", 48'(done_b_cnt - d0), 48'd1);
      chk("b_no_timeout", 48'(to_b_cnt - t0), 48'd0);
      $display("[TB] txn B cmd=3 sends=%0d result=done", hs_b - hs0);
    end
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // Randomized transactions on the main instance.
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 4'($urandom), 3'($urandom), 3'($urandom),
              $urandom_range(0, 3), $urandom_range(0, RA + 1), $urandom_range(1, TA));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/link_mgmt_dllp_tx.md
LINK_MGMT_DLLP_TX -- requirements
Module: link_mgmt_dllp_tx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning cycles to wait for a link partner response after a request DLLP is sent (range 2..65535).
REQ-002 SHALL have parameter MAX_RETRY, default 3, meaning retransmissions allowed after the first send (range 0..7).
REQ-003 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: req_valid  input  1  command request present.
REQ-006 SHALL have ports: req_ready  output  1  block can accept a request.
REQ-007 SHALL have ports: req_priority  input  1  L0p priority bit.
REQ-008 SHALL have ports: req_cmd  input  4  L0p command; cmd[3]=0 is a request expecting a response, cmd[3]=1 is a response (fire-and-forget).
REQ-009 SHALL have ports: req_rsp_payload  input  3  response payload field.
REQ-010 SHALL have ports: req_link_width  input  3  link width field.
REQ-011 SHALL have ports: dllp_valid  output  1  DLLP presented to the link layer.
REQ-012 SHALL have ports: dllp_ready  input  1  link layer accepts DLLP.
REQ-013 SHALL have ports: dllp_data  output  48  {32-bit body, 16-bit CRC}.
REQ-014 SHALL have ports: rsp_valid  input  1  one-cycle pulse: matching partner response received.
REQ-015 SHALL have ports: done  output  1  one-cycle pulse: transaction complete.
REQ-016 SHALL have ports: timeout_err  output  1  one-cycle pulse: retries exhausted.
REQ-017 SHALL have ports: busy  output  1  high in any state other than IDLE.

Function
REQ-018 Body SHALL be [31:24]=8'h28, [23:16]=8'h00, [15]=priority, [14:11]=cmd, [10:8]=rsp_payload, [7:3]=0, [2:0]=link_width.
REQ-019 CRC SHALL be the 16-bit DLLP CRC (polynomial 16'h100B, seed 16'hFFFF, MSB-first over the body bytes 31:24 down to 7:0, result bit-inverted), occupying dllp_data[15:0].
REQ-020 FSM states SHALL be IDLE, BUILD, SEND, WAIT_RSP.
REQ-021 req_ready SHALL equal (state==IDLE); a request is accepted on req_valid&&req_ready, and its fields are captured in registers, moving the FSM to BUILD.
REQ-022 BUILD SHALL last exactly one cycle, registering body and CRC, then go to SEND; dllp_valid rises two cycles after acceptance.
REQ-023 In SEND, dllp_valid SHALL be high and dllp_data stable until dllp_ready; there SHALL be no timeout while stalled.
REQ-024 On SEND handshake with cmd[3]=1: go to IDLE and pulse done in the same cycle.
REQ-025 On SEND handshake with cmd[3]=0: go to WAIT_RSP, and load the timer with TIMEOUT_CYCLES-1.
REQ-026 In WAIT_RSP, rsp_valid SHALL pulse done and return to IDLE; rsp_valid in any other state SHALL be ignored.
REQ-027 On timer reaching 0 without rsp_valid: if retry_cnt<MAX_RETRY, increment retry_cnt and go to SEND (same registered DLLP); else pulse timeout_err and go to IDLE.
REQ-028 rsp_valid in the same cycle as timer expiry SHALL win: done, no retry.
REQ-029 retry_cnt SHALL clear on every request acceptance.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE, req_ready=1, and dllp_valid, done, timeout_err, busy=0; dllp_data, timer and retry_cnt=0.
REQ-031 A reset during SEND or WAIT_RSP SHALL abandon the transaction with no done or timeout_err pulse.

Structure
REQ-032 Shared package link_mgmt_pkg SHALL hold the DLLP type constant 8'h28, the L0p subtype 8'h00, the state enum, and the CRC-16 function.
REQ-033 One sub-module, dllp_crc16, SHALL compute the CRC combinationally from the 32-bit body.

Verification
REQ-034 cmd=4'b1010, prio=1, payload=3'b101, width=3'b100, dllp_ready=1 -> body 32'h28_00_D5_04, CRC matches the package function, done pulses on the send cycle.
REQ-035 cmd=4'b0011 and rsp_valid 10 cycles after send -> exactly one DLLP, done, no timeout_err.
REQ-036 TIMEOUT_CYCLES=8, MAX_RETRY=2, no response -> 3 identical DLLPs 8 cycles apart, then timeout_err, then req_ready=1.
REQ-037 dllp_ready held low for 20 cycles -> dllp_valid and dllp_data stable throughout, no retry counted.
REQ-038 rst asserted in WAIT_RSP -> outputs reach reset values without a clock edge; a subsequent request proceeds normally.
REQ-039 rsp_valid coincident with timer expiry -> done only, no further DLLP.
